// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam int DIV_COUNT_W = 6;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step (shift, trial subtract, restore)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] a_shift;
    logic [WIDTH:0] trial;

    always_comb begin
        a_shift = {a[WIDTH-1:0], q[WIDTH-1]};
        trial   = a_shift - {1'b0, m};
        // A non-negative trial means the divisor fits: keep it and record a 1
        if (!trial[WIDTH]) begin
            a_next = trial;
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            a_next = a_shift;
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle signed/unsigned divide controller, one quotient bit per clock
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e state;
    div_state_e state_next;

    logic [DIV_COUNT_W-1:0] count;
    logic [WIDTH:0]         a_reg;
    logic [WIDTH-1:0]       q_reg;
    logic [WIDTH-1:0]       m_reg;
    logic                   q_neg;
    logic                   r_neg;

    logic [WIDTH:0]         a_step;
    logic [WIDTH-1:0]       q_step;
    logic                   divisor_zero;
    logic                   dividend_neg;
    logic                   divisor_neg;

    assign divisor_zero = (divisor == '0);
    assign dividend_neg = is_signed & dividend[WIDTH-1];
    assign divisor_neg  = is_signed & divisor[WIDTH-1];

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .m      (m_reg),
        .a_next (a_step),
        .q_next (q_step)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (count == DIV_COUNT_W'(DIV_STEPS - 1)) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && divisor_zero) begin
                        quotient    <= DIV_ZERO_QUOT;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (start) begin
                        q_reg <= dividend_neg ? -dividend : dividend;
                        m_reg <= divisor_neg ? -divisor : divisor;
                        a_reg <= '0;
                        count <= '0;
                        q_neg <= dividend_neg ^ divisor_neg;
                        r_neg <= dividend_neg;
                    end
                end
                ITER: begin
                    a_reg <= a_step;
                    q_reg <= q_step;
                    count <= count + 1'b1;
                end
                FIXUP: begin
                    // Magnitude of -2^31 / -1 stays 0x80000000 with q_neg clear, giving the wrapped result
                    quotient    <= q_neg ? -q_reg : q_reg;
                    remainder   <= r_neg ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
